// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   XLEN          : data/address width of the fetch path
//   PC_STEP       : PC increment per fetched instruction
//   NOP           : reset/fill value for buffered instruction words
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   cnt_w()       : width of a counter that must hold the values 0..depth
package fetch_pkg;

    localparam int              XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP     = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO of fetch_entry_t. Slot 0 is always the head, so the
// head is a plain register output. Slots beyond the occupied count are never
// overwritten by a pop, which keeps the head value stable after the FIFO
// drains or is flushed.
//   clk, reset      : clock, asynchronous active-low reset
//   push, push_data : write an entry (ignored when full without a pop)
//   pop             : remove the head (ignored when empty)
//   flush           : empty the FIFO; overrides push and pop
//   head            : current head entry
//   count           : number of occupied entries
//   empty, full     : occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  slot_q [DEPTH];
    fetch_entry_t  slot_d [DEPTH];
    fetch_entry_t  above  [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A full FIFO can still accept a push in the same cycle it pops.
    assign do_push = push & (~full | do_pop) & ~flush;

    // Neighbour each slot shifts from on a pop; the top slot has none.
    for (genvar i = 0; i < DEPTH; i++) begin : g_above
        if (i < DEPTH - 1) begin : g_mid
            assign above[i] = slot_q[i+1];
        end else begin : g_top
            assign above[i] = slot_q[i];
        end
    end

    always_comb begin
        int cnt;
        int tgt;
        cnt = int'(count_q);
        tgt = do_pop ? cnt - 1 : cnt;
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (do_pop && (i + 1 < cnt)) slot_d[i] = above[i];
            if (do_push && (i == tgt))   slot_d[i] = push_data;
        end
        count_d = count_q;
        if (flush) count_d = '0;
        else       count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '{pc: NOP, instr: NOP};
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign head  = slot_q[0];
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch front end. Owns the fetch PC, issues in-order requests to
// instruction memory (req/gnt, responses flagged by rvalid), buffers returned
// words in fetch_fifo and presents them to decode over valid/ready. A redirect
// flushes the buffer and marks in-flight responses for discard.
//   clk, reset                  : clock, asynchronous active-low reset
//   imem_req/addr/gnt           : request channel (addr = PC)
//   imem_rvalid/rdata           : in-order response channel
//   redirect_valid/redirect_pc  : flush and restart fetch
//   id_valid/ready/instr/pc     : decode handshake, head of the FIFO
module instr_fetch_stage #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);
    import fetch_pkg::*;

    localparam int            CW      = cnt_w(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_q, out_d, disc_q, disc_d;
    logic [CW-1:0]   count;
    logic [CW:0]     used;
    logic            run_q;
    logic            empty, full;
    logic            hs, issue, rv_ok, push, pop;
    fetch_entry_t    head, push_data;

    // Requests start the first full cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    assign hs    = id_valid & id_ready;
    assign used  = {1'b0, count} + {1'b0, out_q};
    // used never exceeds DEPTH, so "credits > 0" is used < DEPTH, or a slot
    // freed by this cycle's pop. The id_ready -> imem_req path is deliberate:
    // it is what lets DEPTH=2 sustain one fetch per cycle.
    assign imem_req  = run_q & ((used < DEPTH_W) | hs) & ~redirect_valid;
    assign imem_addr = pc_q;

    assign issue = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol error; drop it.
    assign rv_ok = imem_rvalid & (out_q != '0);
    assign push  = rv_ok & (disc_q == '0) & ~redirect_valid;
    assign pop   = hs & ~redirect_valid;
    assign push_data = '{pc: resp_pc_q, instr: imem_rdata};

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q;
        disc_d    = disc_q;
        if (issue) begin
            pc_d  = pc_q + PC_STEP;
            out_d = out_d + CW'(1);
        end
        if (rv_ok) out_d = out_d - CW'(1);
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            disc_d    = out_d;
        end else begin
            if (rv_ok && (disc_q != '0)) disc_d = disc_q - CW'(1);
            if (push) resp_pc_d = resp_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    assign id_valid = ~empty;
    assign id_instr = head.instr;
    assign id_pc    = head.pc;

    a_credit: assert property (@(posedge clk) disable iff (!reset) used <= DEPTH_W);
    a_disc:   assert property (@(posedge clk) disable iff (!reset) disc_q <= out_q);
    a_full:   assert property (@(posedge clk) disable iff (!reset) !(full && (out_q != '0) && !redirect_valid && !hs && issue));

endmodule
